// File: rtl/glb_ld_addr_gen.sv
// Load-DMA read-address generator for one GLB tile: walks an affine loop nest
// and issues rd_en/rd_addr requests with optional burst/idle duty-cycle gating.
module glb_ld_addr_gen #(
  parameter int unsigned LOOP_LEVEL   = 4,
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned RANGE_WIDTH  = 16,
  parameter int unsigned STRIDE_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           cfg_mode,
  input  logic [ADDR_WIDTH-1:0]                cfg_start_addr,
  input  logic [LOOP_LEVEL*RANGE_WIDTH-1:0]    cfg_range,
  input  logic [LOOP_LEVEL*STRIDE_WIDTH-1:0]   cfg_stride,
  input  logic [RANGE_WIDTH-1:0]               cfg_num_active,
  input  logic [RANGE_WIDTH-1:0]               cfg_num_inactive,
  input  logic                                 start_pulse,
  input  logic                                 rd_ready,
  output logic                                 rd_en,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic                                 busy,
  output logic                                 done_pulse
);

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b10;

  typedef enum logic [1:0] {IDLE, ACTIVE, INACTIVE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   start_q;
  logic [RANGE_WIDTH-1:0]  range_q  [LOOP_LEVEL];
  logic [STRIDE_WIDTH-1:0] stride_q [LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0]  itr_q    [LOOP_LEVEL];
  logic [RANGE_WIDTH-1:0]  num_active_q;
  logic [RANGE_WIDTH-1:0]  num_inactive_q;
  logic [RANGE_WIDTH-1:0]  active_cnt_q;
  logic [RANGE_WIDTH-1:0]  inactive_cnt_q;
  logic                    repeat_q;
  logic                    gate_q;

  logic [RANGE_WIDTH-1:0]  itr_nxt_c [LOOP_LEVEL];
  logic [LOOP_LEVEL-1:0]   at_max_c;
  logic                    last_c;
  logic [ADDR_WIDTH-1:0]   addr_nxt_c;
  logic                    mode_off_c;
  logic                    burst_end_c;
  logic                    idle_end_c;

  assign mode_off_c  = (cfg_mode == MODE_OFF);
  assign burst_end_c = gate_q && (active_cnt_q == num_active_q - RANGE_WIDTH'(1));
  assign idle_end_c  = (inactive_cnt_q == num_inactive_q - RANGE_WIDTH'(1));

  // Ripple-carry iterator advance; a zero range behaves as a single iteration.
  always_comb begin
    last_c     = 1'b1;
    addr_nxt_c = start_q;
    at_max_c   = '0;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      at_max_c[i]  = (range_q[i] == '0) || (itr_q[i] == range_q[i] - RANGE_WIDTH'(1));
      itr_nxt_c[i] = itr_q[i];
      if (last_c) begin
        itr_nxt_c[i] = at_max_c[i] ? '0 : itr_q[i] + RANGE_WIDTH'(1);
      end
      last_c     = last_c & at_max_c[i];
      addr_nxt_c = addr_nxt_c + ADDR_WIDTH'(itr_nxt_c[i]) * ADDR_WIDTH'(stride_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done_pulse     <= 1'b0;
      start_q        <= '0;
      num_active_q   <= '0;
      num_inactive_q <= '0;
      active_cnt_q   <= '0;
      inactive_cnt_q <= '0;
      repeat_q       <= 1'b0;
      gate_q         <= 1'b0;
      for (int i = 0; i < LOOP_LEVEL; i++) begin
        range_q[i]  <= '0;
        stride_q[i] <= '0;
        itr_q[i]    <= '0;
      end
    end else begin
      done_pulse <= 1'b0;
      if (state_q != IDLE && mode_off_c) begin
        // Abort: outstanding request is dropped and no completion is reported.
        state_q        <= IDLE;
        rd_en          <= 1'b0;
        busy           <= 1'b0;
        active_cnt_q   <= '0;
        inactive_cnt_q <= '0;
        for (int i = 0; i < LOOP_LEVEL; i++) itr_q[i] <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_pulse && !mode_off_c) begin
              state_q        <= ACTIVE;
              rd_en          <= 1'b1;
              busy           <= 1'b1;
              rd_addr        <= cfg_start_addr;
              start_q        <= cfg_start_addr;
              num_active_q   <= cfg_num_active;
              num_inactive_q <= cfg_num_inactive;
              repeat_q       <= (cfg_mode == MODE_REPEAT);
              gate_q         <= (cfg_num_active != '0) && (cfg_num_inactive != '0);
              active_cnt_q   <= '0;
              inactive_cnt_q <= '0;
              for (int i = 0; i < LOOP_LEVEL; i++) begin
                range_q[i]  <= cfg_range[i*RANGE_WIDTH +: RANGE_WIDTH];
                stride_q[i] <= cfg_stride[i*STRIDE_WIDTH +: STRIDE_WIDTH];
                itr_q[i]    <= '0;
              end
            end
          end
          ACTIVE: begin
            if (rd_ready) begin
              if (last_c) begin
                // Nest completion outranks the gating burst boundary.
                done_pulse   <= 1'b1;
                active_cnt_q <= '0;
                for (int i = 0; i < LOOP_LEVEL; i++) itr_q[i] <= '0;
                if (repeat_q) begin
                  rd_addr <= start_q;
                end else begin
                  state_q <= IDLE;
                  rd_en   <= 1'b0;
                  busy    <= 1'b0;
                end
              end else begin
                rd_addr <= addr_nxt_c;
                for (int i = 0; i < LOOP_LEVEL; i++) itr_q[i] <= itr_nxt_c[i];
                if (burst_end_c) begin
                  state_q      <= INACTIVE;
                  rd_en        <= 1'b0;
                  active_cnt_q <= '0;
                end else begin
                  active_cnt_q <= active_cnt_q + RANGE_WIDTH'(1);
                end
              end
            end
          end
          INACTIVE: begin
            if (idle_end_c) begin
              state_q        <= ACTIVE;
              rd_en          <= 1'b1;
              inactive_cnt_q <= '0;
            end else begin
              inactive_cnt_q <= inactive_cnt_q + RANGE_WIDTH'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            rd_en   <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glb_ld_addr_gen.sv
// Self-checking bench for glb_ld_addr_gen: directed vector table, hand-written
// multi-cycle sequences and randomized runs against an index-based reference model.
module tb_glb_ld_addr_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cfg_mode;
  logic [21:0] cfg_start_addr;
  logic [63:0] cfg_range;
  logic [63:0] cfg_stride;
  logic [15:0] cfg_num_active;
  logic [15:0] cfg_num_inactive;
  logic        start_pulse;
  logic        rd_ready;
  logic        rd_en;
  logic [21:0] rd_addr;
  logic        busy;
  logic        done_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  glb_ld_addr_gen dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_mode         (cfg_mode),
    .cfg_start_addr   (cfg_start_addr),
    .cfg_range        (cfg_range),
    .cfg_stride       (cfg_stride),
    .cfg_num_active   (cfg_num_active),
    .cfg_num_inactive (cfg_num_inactive),
    .start_pulse      (start_pulse),
    .rd_ready         (rd_ready),
    .rd_en            (rd_en),
    .rd_addr          (rd_addr),
    .busy             (busy),
    .done_pulse       (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]        mode;
    logic [21:0]       start;
    logic [3:0][15:0]  rng;
    logic [3:0][15:0]  strd;
    logic [15:0]       na;
    logic [15:0]       ni;
    logic [7:0]        done_cyc;
    logic [15:0]       en_pat;
    logic [7:0]        n_words;
    logic [5:0][21:0]  addr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] mode, input logic [21:0] start,
                              input logic [63:0] rng, input logic [63:0] strd,
                              input logic [15:0] na, input logic [15:0] ni,
                              input logic [7:0] done_cyc, input logic [15:0] en_pat,
                              input logic [7:0] n_words,
                              input logic [21:0] a0, input logic [21:0] a1, input logic [21:0] a2,
                              input logic [21:0] a3, input logic [21:0] a4, input logic [21:0] a5);
    vec_t v;
    v.mode = mode; v.start = start; v.rng = rng; v.strd = strd;
    v.na = na; v.ni = ni; v.done_cyc = done_cyc; v.en_pat = en_pat; v.n_words = n_words;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.addr[3] = a3; v.addr[4] = a4; v.addr[5] = a5;
    return v;
  endfunction

  task automatic scramble_cfg();
    cfg_start_addr   = 22'($urandom);
    cfg_range        = {$urandom, $urandom};
    cfg_stride       = {$urandom, $urandom};
    cfg_num_active   = 16'($urandom);
    cfg_num_inactive = 16'($urandom);
  endtask

  // Returns at the negedge of the first observation cycle after the start edge.
  task automatic launch(input logic [1:0] mode, input logic [21:0] st, input logic [63:0] rng,
                        input logic [63:0] strd, input logic [15:0] na, input logic [15:0] ni);
    @(negedge clk);
    cfg_mode = mode; cfg_start_addr = st; cfg_range = rng; cfg_stride = strd;
    cfg_num_active = na; cfg_num_inactive = ni;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic [21:0] seen [$];
    v = vecs[k];
    rd_ready = 1'b1;
    launch(v.mode, v.start, v.rng, v.strd, v.na, v.ni);
    scramble_cfg();
    for (int c = 0; c <= int'(v.done_cyc); c++) begin
      check($sformatf("vec%0d c%0d rd_en", k, c), 64'(rd_en), 64'(v.en_pat[c]));
      check($sformatf("vec%0d c%0d done", k, c), 64'(done_pulse), 64'(c == int'(v.done_cyc)));
      check($sformatf("vec%0d c%0d busy", k, c), 64'(busy), 64'(c != int'(v.done_cyc)));
      if (rd_en) seen.push_back(rd_addr);
      @(negedge clk);
    end
    check($sformatf("vec%0d words", k), 64'(seen.size()), 64'(v.n_words));
    for (int i = 0; i < int'(v.n_words) && i < seen.size(); i++)
      check($sformatf("vec%0d addr%0d", k, i), 64'(seen[i]), 64'(v.addr[i]));
  endtask

  // Backpressure on the 2nd request: address and valid must hold through the stall.
  task automatic seq_backpressure();
    logic [21:0] exp_a [9] = '{22'h100, 22'h108, 22'h108, 22'h108, 22'h108,
                               22'h110, 22'h140, 22'h148, 22'h150};
    rd_ready = 1'b1;
    launch(2'b01, 22'h100, {16'd0, 16'd0, 16'd2, 16'd3}, {16'd0, 16'd0, 16'd64, 16'd8}, 16'd0, 16'd0);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp c%0d rd_en", c), 64'(rd_en), 64'(c < 9));
      check($sformatf("bp c%0d done", c), 64'(done_pulse), 64'(c == 9));
      if (c < 9) check($sformatf("bp c%0d addr", c), 64'(rd_addr), 64'(exp_a[c]));
      rd_ready = !(c >= 1 && c <= 3);
      @(negedge clk);
    end
    rd_ready = 1'b1;
  endtask

  // REPEAT self-restart, then abort via cfg_mode OFF just before a completion.
  task automatic seq_repeat();
    rd_ready = 1'b1;
    launch(2'b10, 22'h0, {16'd0, 16'd0, 16'd0, 16'd4}, {16'd0, 16'd0, 16'd0, 16'd8}, 16'd0, 16'd0);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("rpt c%0d rd_en", c), 64'(rd_en), 64'd1);
      check($sformatf("rpt c%0d addr", c), 64'(rd_addr), 64'(8 * (c % 4)));
      check($sformatf("rpt c%0d done", c), 64'(done_pulse), 64'(c > 0 && (c % 4) == 0));
      if (c < 11) @(negedge clk);
    end
    cfg_mode = 2'b00;
    rd_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rpt off%0d busy", c), 64'(busy), 64'd0);
      check($sformatf("rpt off%0d rd_en", c), 64'(rd_en), 64'd0);
      check($sformatf("rpt off%0d done", c), 64'(done_pulse), 64'd0);
    end
    rd_ready = 1'b1;
  endtask

  // Start while busy is ignored; reset mid-run clears outputs and never reports done.
  task automatic seq_reset();
    rd_ready = 1'b1;
    launch(2'b01, 22'h100, {16'd0, 16'd0, 16'd2, 16'd3}, {16'd0, 16'd0, 16'd64, 16'd8}, 16'd0, 16'd0);
    check("rst c0 addr", 64'(rd_addr), 64'h100);
    cfg_start_addr = 22'h3000;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    check("rst c1 addr", 64'(rd_addr), 64'h108);
    check("rst c1 busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst rd_en", 64'(rd_en), 64'd0);
    check("rst rd_addr", 64'(rd_addr), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done_pulse), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("rst idle%0d done", c), 64'(done_pulse), 64'd0);
      check($sformatf("rst idle%0d busy", c), 64'(busy), 64'd0);
    end
    cfg_mode = 2'b00;
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    @(negedge clk);
    check("off start busy", 64'(busy), 64'd0);
    check("off start rd_en", 64'(rd_en), 64'd0);
  endtask

  // Randomized run; reference is the flat word list plus a per-cycle handshake model.
  task automatic run_random(input int r);
    logic [3:0][15:0] rng;
    logic [3:0][15:0] strd;
    logic [21:0] st;
    logic [15:0] na, ni;
    logic [1:0]  mode;
    logic [21:0] exp_q [$];
    longint      a;
    int          total, rem, e, abort_at, cyc;
    bit          rpt, gate, rdy, abort;
    bit          m_busy, m_en, m_done;
    int          m_idx, m_burst, m_idle;

    for (int i = 0; i < 4; i++) begin
      rng[i]  = 16'($urandom_range(0, 3));
      strd[i] = 16'($urandom);
    end
    st   = ((r % 5) == 0) ? 22'h3FFFF0 : 22'($urandom);
    na   = 16'($urandom_range(0, 3));
    ni   = 16'($urandom_range(0, 3));
    mode = 2'($urandom_range(1, 3));
    rpt  = (mode == 2'b10);
    gate = (na != 0) && (ni != 0);

    total = 1;
    for (int i = 0; i < 4; i++) total *= (rng[i] == 0) ? 1 : int'(rng[i]);
    for (int n = 0; n < total; n++) begin
      rem = n;
      a   = longint'(st);
      for (int i = 0; i < 4; i++) begin
        e   = (rng[i] == 0) ? 1 : int'(rng[i]);
        a  += longint'(rem % e) * longint'(strd[i]);
        rem = rem / e;
      end
      exp_q.push_back(22'(a));
    end
    if (rpt) abort_at = int'($urandom_range(total + 5, 3 * total + 20));
    else abort_at = (($urandom % 4) == 0) ? int'($urandom_range(1, total + 3)) : -1;

    rd_ready = 1'b1;
    launch(mode, st, rng, strd, na, ni);
    m_busy = 1'b1; m_en = 1'b1; m_done = 1'b0; m_idx = 0; m_burst = 0; m_idle = 0;
    cyc = 0;
    while (1) begin
      check($sformatf("rnd%0d c%0d rd_en", r, cyc), 64'(rd_en), 64'(m_en));
      check($sformatf("rnd%0d c%0d busy", r, cyc), 64'(busy), 64'(m_busy));
      check($sformatf("rnd%0d c%0d done", r, cyc), 64'(done_pulse), 64'(m_done));
      if (m_en) check($sformatf("rnd%0d c%0d addr", r, cyc), 64'(rd_addr), 64'(exp_q[m_idx]));
      if (!m_busy) break;
      if (cyc > 3000) begin
        check($sformatf("rnd%0d cycle budget", r), 64'd1, 64'(m_busy ? 0 : 1));
        break;
      end
      rdy   = ($urandom % 4) != 0;
      abort = (cyc == abort_at);
      rd_ready    = rdy;
      cfg_mode    = abort ? 2'b00 : mode;
      start_pulse = ($urandom % 8) == 0;
      scramble_cfg();
      m_done = 1'b0;
      if (abort) begin
        m_busy = 1'b0; m_en = 1'b0;
      end else if (!m_en) begin
        m_idle--;
        if (m_idle == 0) m_en = 1'b1;
      end else if (rdy) begin
        m_idx++;
        if (m_idx == total) begin
          m_done = 1'b1; m_idx = 0; m_burst = 0;
          if (!rpt) begin m_busy = 1'b0; m_en = 1'b0; end
        end else begin
          m_burst++;
          if (gate && m_burst == int'(na)) begin
            m_burst = 0; m_idle = int'(ni); m_en = 1'b0;
          end
        end
      end
      cyc++;
      @(negedge clk);
    end
    start_pulse = 1'b0;
    rd_ready    = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_mode = 2'b00; cfg_start_addr = '0; cfg_range = '0; cfg_stride = '0;
    cfg_num_active = '0; cfg_num_inactive = '0; start_pulse = 1'b0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rd_en", 64'(rd_en), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done_pulse), 64'd0);
    reset = 1'b0;

    // {mode, start, range L3..L0, stride L3..L0, active, inactive, done cycle, rd_en pattern, words, addrs}
    vecs[0] = mk(2'b01, 22'h100, {16'd0, 16'd0, 16'd2, 16'd3}, {16'd0, 16'd0, 16'd64, 16'd8},
                 16'd0, 16'd0, 8'd6, 16'h003F, 8'd6,
                 22'h100, 22'h108, 22'h110, 22'h140, 22'h148, 22'h150);
    vecs[1] = mk(2'b01, 22'h0, {16'd0, 16'd0, 16'd0, 16'd5}, {16'd0, 16'd0, 16'd0, 16'd4},
                 16'd2, 16'd3, 8'd11, 16'h0463, 8'd5,
                 22'h0, 22'h4, 22'h8, 22'hC, 22'h10, 22'h0);
    vecs[2] = mk(2'b01, 22'h3FFFF8, {16'd0, 16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd8},
                 16'd0, 16'd0, 8'd3, 16'h0007, 8'd3,
                 22'h3FFFF8, 22'h0, 22'h8, 22'h0, 22'h0, 22'h0);
    vecs[3] = mk(2'b01, 22'h20, {16'd0, 16'd3, 16'd0, 16'd2}, {16'd0, 16'h1000, 16'h100, 16'd1},
                 16'd0, 16'd0, 8'd6, 16'h003F, 8'd6,
                 22'h20, 22'h21, 22'h1020, 22'h1021, 22'h2020, 22'h2021);
    vecs[4] = mk(2'b11, 22'h5, {16'd0, 16'd0, 16'd2, 16'd2}, {16'd0, 16'd0, 16'd2, 16'h10},
                 16'd0, 16'd0, 8'd4, 16'h000F, 8'd4,
                 22'h5, 22'h15, 22'h7, 22'h17, 22'h0, 22'h0);
    vecs[5] = mk(2'b01, 22'h0, {16'd0, 16'd0, 16'd0, 16'd4}, {16'd0, 16'd0, 16'd0, 16'd3},
                 16'd1, 16'd0, 8'd4, 16'h000F, 8'd4,
                 22'h0, 22'h3, 22'h6, 22'h9, 22'h0, 22'h0);
    vecs[6] = mk(2'b01, 22'h0, {16'd0, 16'd0, 16'd0, 16'd3}, {16'd0, 16'd0, 16'd0, 16'd1},
                 16'd1, 16'd1, 8'd5, 16'h0015, 8'd3,
                 22'h0, 22'h1, 22'h2, 22'h0, 22'h0, 22'h0);
    vecs[7] = mk(2'b01, 22'h0, {16'd0, 16'd0, 16'd2, 16'd2}, {16'd0, 16'd0, 16'h40, 16'd4},
                 16'd2, 16'd1, 8'd5, 16'h001B, 8'd4,
                 22'h0, 22'h4, 22'h40, 22'h44, 22'h0, 22'h0);

    for (int k = 0; k < 8; k++) run_vec(k);
    seq_backpressure();
    seq_repeat();
    seq_reset();
    for (int r = 0; r < 30; r++) run_random(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
